dm_arbiter: RTL and testbench

- Two-master arbiter and sequencer in front of the word-wide data memory (single WE, combinational read, word index Addr[13:2]).
- Master 0 is the pipeline M-stage; master 1 is the debug/bridge port. Both share one memory port.
- Partial stores (sb/sh) are sequenced as read-modify-write, so the memory stays word-only.

---
 rtl/dm_arbiter_pkg.sv | 21 ++
 rtl/dm_be_merge.sv | 30 +++
 rtl/dm_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_dm_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   - arb_state_t : sequencer state encoding (ARB_IDLE, ARB_RMW_WR)
//   - BE_FULL     : byte-enable pattern of a full-word store
//   - M0 / M1     : master index constants used by the round-robin pointer
// No ports (package).
// -----------------------------------------------------------------------------
package dm_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_RMW_WR = 1'b1
  } arb_state_t;

  localparam logic [3:0] BE_FULL = 4'b1111;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/dm_be_merge.sv
// -----------------------------------------------------------------------------
// dm_be_merge
// Combinational byte-lane merge for partial stores: each byte lane takes the
// write data when its enable is set, otherwise keeps the word read from memory.
// Ports:
//   i_be     [3:0]  byte enables, bit n selects lane n (bits 8n+7:8n)
//   i_wd     [31:0] lane-aligned write data
//   i_rd     [31:0] current memory word
//   o_merged [31:0] merged word to be written back
// -----------------------------------------------------------------------------
module dm_be_merge (
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wd,
  input  logic [31:0] i_rd,
  output logic [31:0] o_merged
);

  // Per-lane select between store data and the old memory contents
  always_comb begin
    o_merged = i_rd;
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) begin
        o_merged[i*8 +: 8] = i_wd[i*8 +: 8];
      end else begin
        o_merged[i*8 +: 8] = i_rd[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Two-master round-robin arbiter and store sequencer in front of a word-wide
// data memory with a single write enable and combinational read. Full-word
// stores write in the grant cycle; partial stores are done as read (grant
// cycle) then write of the merged word (RMW_WR cycle).
//
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   mN_req/we/be/addr/wd/pc    master N request fields (N = 0: pipeline M-stage,
//                              N = 1: debug/bridge), held until mN_gnt
//   mN_gnt                     one-cycle accept pulse (combinational)
//   mN_rvalid, mN_rdata        registered read response, one cycle after gnt
//   mem_we, mem_addr, mem_wd   memory port, zero whenever not in use
//   mem_rd                     memory read data, combinational from mem_addr
//
// Optional build macro DM_ARB_TRACE_EN: prints one line per memory write
// cycle with the owning PC, word address and full written word.
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wd,
  input  logic [31:0]       m0_pc,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wd,
  input  logic [31:0]       m1_pc,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  import dm_arbiter_pkg::*;

  arb_state_t        r_state;
  logic              r_last_owner;
  logic [ADDR_W-1:0] r_rmw_addr;
  logic [DATA_W-1:0] r_rmw_data;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_any_req;
  logic              w_sel;
  logic              w_we;
  logic [3:0]        w_be;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_word_addr;
  logic [DATA_W-1:0] w_wd;
  logic              w_full;
  logic              w_partial;
  logic [DATA_W-1:0] w_merged;
  logic              w_unused_lsb;

  // Winner selection: a lone requester wins, a tie goes to the master that
  // did not own the previous grant
  always_comb begin
    w_any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
      w_sel = ~r_last_owner;
    end else if (m1_req) begin
      w_sel = M1;
    end else begin
      w_sel = M0;
    end
  end

  // Request fields of the current winner
  always_comb begin
    if (w_sel == M1) begin
      w_we   = m1_we;
      w_be   = m1_be;
      w_addr = m1_addr;
      w_wd   = m1_wd;
    end else begin
      w_we   = m0_we;
      w_be   = m0_be;
      w_addr = m0_addr;
      w_wd   = m0_wd;
    end
  end

  assign w_word_addr  = {w_addr[ADDR_W-1:2], 2'b00};
  assign w_full       = w_we & (w_be == BE_FULL);
  assign w_partial    = w_we & (w_be != 4'b0000) & (w_be != BE_FULL);
  assign w_unused_lsb = ^w_addr[1:0];

  dm_be_merge u_merge (
    .i_be     (w_be),
    .i_wd     (w_wd),
    .i_rd     (mem_rd),
    .o_merged (w_merged)
  );

  // Grant and memory port drive; gated by reset so nothing leaks out while
  // reset is asserted, including an RMW write cut short by reset
  always_comb begin
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = {ADDR_W{1'b0}};
    mem_wd   = {DATA_W{1'b0}};
    if (reset) begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            m0_gnt   = (w_sel == M0);
            m1_gnt   = (w_sel == M1);
            mem_addr = w_word_addr;
            if (w_full) begin
              mem_we = 1'b1;
              mem_wd = w_wd;
            end else begin
              mem_we = 1'b0;
              mem_wd = {DATA_W{1'b0}};
            end
          end else begin
            mem_addr = {ADDR_W{1'b0}};
          end
        end
        ARB_RMW_WR: begin
          mem_we   = 1'b1;
          mem_addr = r_rmw_addr;
          mem_wd   = r_rmw_data;
        end
        default: begin
          mem_we = 1'b0;
        end
      endcase
    end else begin
      mem_we = 1'b0;
    end
  end

  // Sequencer: round-robin pointer, read capture, RMW latch and state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_IDLE;
      r_last_owner <= M1;
      r_rmw_addr   <= {ADDR_W{1'b0}};
      r_rmw_data   <= {DATA_W{1'b0}};
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_m0_rdata   <= {DATA_W{1'b0}};
      r_m1_rdata   <= {DATA_W{1'b0}};
    end else begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_last_owner <= w_sel;
            if (!w_we) begin
              if (w_sel == M1) begin
                r_m1_rvalid <= 1'b1;
                r_m1_rdata  <= mem_rd;
              end else begin
                r_m0_rvalid <= 1'b1;
                r_m0_rdata  <= mem_rd;
              end
            end else if (w_partial) begin
              r_rmw_addr <= w_word_addr;
              r_rmw_data <= w_merged;
              r_state    <= ARB_RMW_WR;
            end
          end
        end
        ARB_RMW_WR: r_state <= ARB_IDLE;
        default:    r_state <= ARB_IDLE;
      endcase
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

`ifdef DM_ARB_TRACE_EN
  logic [31:0] r_rmw_pc;
  logic [31:0] w_pc;

  assign w_pc = (w_sel == M1) ? m1_pc : m0_pc;

  // PC of the pending RMW, so the write-back line names its owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rmw_pc <= 32'h0000_0000;
    end else if ((r_state == ARB_IDLE) && w_any_req && w_partial) begin
      r_rmw_pc <= w_pc;
    end
  end

  // One trace line per memory write cycle
  always_ff @(posedge clk) begin
    if (mem_we) begin
      $display("@%h: *%h <= %h", (r_state == ARB_RMW_WR) ? r_rmw_pc : w_pc,
               mem_addr, mem_wd);
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^{m0_pc, m1_pc};
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Scoreboard bench: read stimulus pushes the expected word into a per-master
// queue and the expected grant order into a grant queue; a monitor on the
// falling edge pops and compares on every rvalid / gnt.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr, m0_wd, m0_pc, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wd, m1_pc, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [0:4095];

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic        gexp [$];
  logic        gnt_chk_en;
  logic        exp_rv0, exp_rv1;

  int checks;
  int failures;

  dm_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_be     (m0_be),
    .m0_addr   (m0_addr),
    .m0_wd     (m0_wd),
    .m0_pc     (m0_pc),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_be     (m1_be),
    .m1_addr   (m1_addr),
    .m1_wd     (m1_wd),
    .m1_pc     (m1_pc),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory model: combinational read, write on rising edge
  assign mem_rd = mem[mem_addr[13:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[13:2]] <= mem_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wd = wd; m1_pc = 32'h0000_2000;
    end else begin
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wd = wd; m0_pc = 32'h0000_1000;
    end
  endtask

  // Issue one request, wait (bounded) for its grant and check the memory port
  task automatic issue(input logic m, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd, input int exp_wait);
    int   waited;
    logic got;
    logic full;
    waited = 0;
    got    = 1'b0;
    full   = we && (be == 4'hF);
    drive(m, 1'b1, we, be, addr, wd);
    while (!got && waited < 20) begin
      @(negedge clk);
      if (m ? m1_gnt : m0_gnt) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout: master=%0d no grant within 20 cycles", m);
    end else begin
      chk("gnt_wait", 32'(waited), 32'(exp_wait));
      chk("gnt_mem_addr", mem_addr, {addr[31:2], 2'b00});
      chk("gnt_mem_we", {31'd0, mem_we}, {31'd0, full});
      chk("gnt_mem_wd", mem_wd, full ? wd : 32'h0);
    end
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Monitor: read responses, rvalid latency, grant order, exclusive grants
  always @(negedge clk) begin
    if (m0_rvalid || exp_rv0) chk("m0_rvalid_latency", {31'd0, m0_rvalid}, {31'd0, exp_rv0});
    if (m1_rvalid || exp_rv1) chk("m1_rvalid_latency", {31'd0, m1_rvalid}, {31'd0, exp_rv1});
    if (m0_rvalid) begin
      if (q0.size() == 0) chk("m0_rvalid_unexpected", 32'd1, 32'd0);
      else chk("m0_rdata", m0_rdata, q0.pop_front());
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) chk("m1_rvalid_unexpected", 32'd1, 32'd0);
      else chk("m1_rdata", m1_rdata, q1.pop_front());
    end
    if (m0_gnt && m1_gnt) chk("dual_gnt", 32'd1, 32'd0);
    if (gnt_chk_en && (m0_gnt || m1_gnt)) begin
      if (gexp.size() == 0) chk("gnt_unexpected", 32'd1, 32'd0);
      else chk("gnt_order", {31'd0, m1_gnt}, {31'd0, gexp.pop_front()});
    end
    exp_rv0 = m0_gnt && !m0_we;
    exp_rv1 = m1_gnt && !m1_we;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    gnt_chk_en = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    #1;
    mem[64]  <= 32'hDEAD_BEEF;  // 0x100
    mem[65]  <= 32'h5566_7788;  // 0x104
    mem[192] <= 32'hAABB_CCDD;  // 0x300
    mem[4]   <= 32'h1122_3344;  // 0x010

    // Reset state, with a full-word write request pending
    repeat (2) @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hCAFE_F00D);
    @(negedge clk);
    chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_m0_gnt",    {31'd0, m0_gnt}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_wd",    mem_wd, 32'h0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m0_rdata",  m0_rdata, 32'h0);
    chk("rst_m1_rdata",  m1_rdata, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;

    // Contention: both masters read for 6 cycles, m0 wins the first tie
    gnt_chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gexp.push_back(1'b0); gexp.push_back(1'b1);
      q0.push_back(32'hDEAD_BEEF); q1.push_back(32'h5566_7788);
    end
    drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h104, 32'h0);
    repeat (6) @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    gnt_chk_en = 1'b0;
    chk("contention_grants_left", 32'(gexp.size()), 32'd0);
    @(posedge clk); #1;

    // Single read, full-word write then read-back, misaligned back-to-back read
    q0.push_back(32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 0);
    issue(1'b1, 1'b1, 4'hF, 32'h204, 32'h1234_5678, 0);
    q0.push_back(32'h1234_5678);
    issue(1'b0, 1'b0, 4'h0, 32'h204, 32'h0, 0);
    q1.push_back(32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 4'h0, 32'h103, 32'h0, 0);

    // Partial write: RMW on 0x300, m1 read waits out the write cycle
    drive(1'b0, 1'b1, 1'b1, 4'b0010, 32'h300, 32'h0000_EE00);
    @(negedge clk);
    chk("rmw_gnt",      {31'd0, m0_gnt}, 32'd1);
    chk("rmw_rd_we",    {31'd0, mem_we}, 32'd0);
    chk("rmw_rd_addr",  mem_addr, 32'h300);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    q1.push_back(32'hAABB_EEDD);
    drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
    @(negedge clk);
    chk("rmw_wr_we",     {31'd0, mem_we}, 32'd1);
    chk("rmw_wr_addr",   mem_addr, 32'h300);
    chk("rmw_wr_data",   mem_wd, 32'hAABB_EEDD);
    chk("rmw_m1_wait",   {31'd0, m1_gnt}, 32'd0);
    @(posedge clk); #1;
    chk("rmw_mem_word",  mem[192], 32'hAABB_EEDD);
    @(negedge clk);
    chk("rmw_m1_gnt",    {31'd0, m1_gnt}, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // be=0000 write: granted, memory untouched
    issue(1'b1, 1'b1, 4'b0000, 32'h300, 32'hFFFF_FFFF, 0);
    chk("noop_mem_word", mem[192], 32'hAABB_EEDD);

    // Reset in the RMW write cycle aborts the write
    drive(1'b0, 1'b1, 1'b1, 4'b0001, 32'h10, 32'h0000_00AA);
    @(negedge clk);
    chk("abort_gnt", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("abort_pre_we",   {31'd0, mem_we}, 32'd1);
    chk("abort_pre_data", mem_wd, 32'h1122_33AA);
    #2 reset = 1'b0;
    #1;
    chk("abort_we",   {31'd0, mem_we}, 32'd0);
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_wd",   mem_wd, 32'h0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_mem_word", mem[4], 32'h1122_3344);
    q0.push_back(32'h1122_3344);
    issue(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 0);

    repeat (3) @(posedge clk); #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
